edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_arb_pkg.sv | 16 +
 rtl/edge_chan.sv | 33 +++
 rtl/edge_event_arbiter.sv | 149 ++++++++++++++
 tb/tb_edge_event_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared constants and channel state encoding for the edge event arbiter.
// Optional build macro used by the top: EDGE_ARB_PRESCALE_EN.
package edge_arb_pkg;

   // Default configuration
   localparam int NCH_DEFAULT      = 4;
   localparam int PRESCALE_DEFAULT = 4;

   // Channel FSM state type; encoding 2'd3 is unreachable and recovers to ZERO
   typedef logic [1:0] edge_state_t;

   localparam edge_state_t ST_ZERO   = 2'd0;
   localparam edge_state_t ST_CHANGE = 2'd1;
   localparam edge_state_t ST_ONE    = 2'd2;

endpackage : edge_arb_pkg

// File: rtl/edge_chan.sv
// Per-channel rising-edge qualifier. The FSM advances only on sample ticks,
// so a level must be seen high on a tick after being seen low on a tick.
// rise is combinational and marks the ZERO->CHANGE transition being taken
// on the current clock edge.
module edge_chan
   import edge_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic signal,
   output logic rise
);

   edge_state_t r_state;

   assign rise = tick & signal & (r_state == ST_ZERO);

   // Tick-gated ZERO/CHANGE/ONE state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_ZERO;
      end else if (tick) begin
         case (r_state)
            ST_ZERO:   r_state <= signal ? ST_CHANGE : ST_ZERO;
            ST_CHANGE: r_state <= signal ? ST_ONE    : ST_ZERO;
            ST_ONE:    r_state <= signal ? ST_ONE    : ST_ZERO;
            default:   r_state <= ST_ZERO;
         endcase
      end
   end

endmodule : edge_chan

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: NCH channel edge detectors feed a pending vector that
// a round-robin arbiter drains into a single registered event output.
// Optional macro EDGE_ARB_PRESCALE_EN: when defined, channel FSMs advance
// only once every PRESCALE clocks; otherwise they advance every clock.
//
// Handshake: evt_valid/evt_id are registered. An event transfers on a clock
// edge where evt_valid and evt_ready are both high. While evt_valid is high
// and evt_ready is low the event is held unchanged. The output register
// reloads when it is empty or its current event is being accepted.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int NCH      = NCH_DEFAULT,
   parameter int PRESCALE = PRESCALE_DEFAULT
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NCH-1:0]           signal,
   output logic                     evt_valid,
   output logic [$clog2(NCH)-1:0]   evt_id,
   input  logic                     evt_ready,
   output logic [NCH-1:0]           ovf,
   input  logic                     ovf_clr
);

   localparam int IDW = $clog2(NCH);

   // Parameter legality checks at elaboration
   if (NCH < 2 || NCH > 16) begin : g_bad_nch
      $error("edge_event_arbiter: NCH must be in 2..16");
   end
   if (PRESCALE < 2) begin : g_bad_prescale
      $error("edge_event_arbiter: PRESCALE must be >= 2");
   end

   logic             w_tick;
   logic [NCH-1:0]   w_rise;
   logic             w_load;
   logic             w_any;
   logic             w_found;
   logic [IDW-1:0]   w_grant;
   logic [NCH-1:0]   w_grant_clr;
   logic [NCH-1:0]   w_pending_nxt;
   logic [NCH-1:0]   w_ovf_set;

   logic [NCH-1:0]   r_pending;
   logic [NCH-1:0]   r_ovf;
   logic             r_evt_valid;
   logic [IDW-1:0]   r_evt_id;
   logic [IDW-1:0]   r_ptr;

`ifdef EDGE_ARB_PRESCALE_EN
   localparam int PW = $clog2(PRESCALE);

   logic [PW-1:0] r_pre_cnt;

   // Free-running sample counter 0..PRESCALE-1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre_cnt <= '0;
      end else if (r_pre_cnt == PW'(PRESCALE - 1)) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

   assign w_tick = (r_pre_cnt == PW'(PRESCALE - 1));
`else
   assign w_tick = 1'b1;
`endif

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      edge_chan u_chan (
         .clk    (clk),
         .reset  (reset),
         .tick   (w_tick),
         .signal (signal[gi]),
         .rise   (w_rise[gi])
      );
   end

   assign w_load = ~r_evt_valid | evt_ready;
   assign w_any  = |r_pending;

   // Round-robin search starting just after the last granted channel
   always_comb begin
      int unsigned   idx;
      logic [IDW-1:0] sel;
      w_found = 1'b0;
      w_grant = '0;
      idx     = 0;
      sel     = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(r_ptr) + k) % NCH;
         sel = IDW'(idx);
         if (!w_found && r_pending[sel]) begin
            w_found = 1'b1;
            w_grant = sel;
         end
      end
   end

   // Next pending vector and overflow detection; a new edge beats a grant
   always_comb begin
      w_grant_clr   = '0;
      w_pending_nxt = '0;
      w_ovf_set     = '0;
      for (int i = 0; i < NCH; i++) begin
         w_grant_clr[i]   = w_load & w_found & (w_grant == IDW'(i));
         w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_grant_clr[i]);
         w_ovf_set[i]     = w_rise[i] & r_pending[i] & ~w_grant_clr[i];
      end
   end

   // Pending and sticky overflow registers; a new overflow beats ovf_clr
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
         r_ovf     <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         r_ovf     <= (r_ovf & ~{NCH{ovf_clr}}) | w_ovf_set;
      end
   end

   // Output event register and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_ptr       <= IDW'(NCH - 1);
      end else if (w_load) begin
         if (w_any) begin
            r_evt_valid <= 1'b1;
            r_evt_id    <= w_grant;
            r_ptr       <= w_grant;
         end else begin
            r_evt_valid <= 1'b0;
         end
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_id    = r_evt_id;
   assign ovf       = r_ovf;

endmodule : edge_event_arbiter

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with NCH=4. Inputs change 1 time
// unit after a rising edge; outputs are observed at that same point.
// The prescaled scenario is compiled only with EDGE_ARB_PRESCALE_EN.
`timescale 1ns/1ps
module tb_edge_event_arbiter;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] signal = '0;
  logic           evt_valid;
  logic [1:0]     evt_id;
  logic           evt_ready = 1'b0;
  logic [NCH-1:0] ovf;
  logic           ovf_clr = 1'b0;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int hs_cnt   = 0;
  int base;

  edge_event_arbiter #(.NCH(NCH), .PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .signal    (signal),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // clock
  always #5 clk = ~clk;

  // accepted-event counter
  always @(posedge clk) begin
    if (!reset && evt_valid && evt_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    signal    = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // reset state
    do_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id",    32'(evt_id),    32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);

    // single edge on channel 2, two-edge latency
    evt_ready = 1'b1;
    signal[2] = 1'b1;
    step(1);
    chk("s1_valid_pend", 32'(evt_valid), 32'd0);
    step(1);
    chk("s1_valid", 32'(evt_valid), 32'd1);
    chk("s1_id",    32'(evt_id),    32'd2);
    step(1);
    chk("s1_valid_drop", 32'(evt_valid), 32'd0);

    // four simultaneous edges, then a second burst after ptr=3
    do_reset();
    evt_ready = 1'b1;
    signal    = 4'hF;
    step(1);
    chk("s2_none_yet", 32'(evt_valid), 32'd0);
    step(1);
    chk("s2_id0", 32'(evt_id), 32'd0);
    chk("s2_v0",  32'(evt_valid), 32'd1);
    step(1);
    chk("s2_id1", 32'(evt_id), 32'd1);
    step(1);
    chk("s2_id2", 32'(evt_id), 32'd2);
    step(1);
    chk("s2_id3", 32'(evt_id), 32'd3);
    chk("s2_v3",  32'(evt_valid), 32'd1);
    step(1);
    chk("s2_empty", 32'(evt_valid), 32'd0);
    signal = 4'h0;
    step(2);
    signal = 4'hF;
    step(2);
    chk("s2b_v0",  32'(evt_valid), 32'd1);
    chk("s2b_id0", 32'(evt_id),    32'd0);
    step(4);
    chk("s2b_empty", 32'(evt_valid), 32'd0);
    chk("s2_no_ovf", 32'(ovf), 32'd0);

    // stalled consumer: ch1 granted, re-armed (pending), then lost (ovf)
    do_reset();
    signal[1] = 1'b1;
    step(2);
    chk("s3_v", 32'(evt_valid), 32'd1);
    chk("s3_id", 32'(evt_id), 32'd1);
    signal = 4'h0;
    step(1);
    signal[1] = 1'b1;
    step(1);
    chk("s3_pend_no_ovf", 32'(ovf), 32'd0);
    signal = 4'h0;
    step(1);
    signal[1] = 1'b1;
    step(1);
    chk("s3_ovf", 32'(ovf), 32'h2);
    chk("s3_id_held", 32'(evt_id), 32'd1);
    step(3);
    chk("s3_v_held", 32'(evt_valid), 32'd1);
    chk("s3_id_held2", 32'(evt_id), 32'd1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("s3_ovf_clr", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    step(1);
    chk("s3_next_v",  32'(evt_valid), 32'd1);
    chk("s3_next_id", 32'(evt_id),    32'd1);
    step(1);
    chk("s3_drained", 32'(evt_valid), 32'd0);

    // reset while presenting id 3 with ovf[3] set
    do_reset();
    signal[3] = 1'b1;
    step(2);
    chk("s5_id3", 32'(evt_id), 32'd3);
    signal = 4'h0;
    step(1);
    signal[3] = 1'b1;
    step(1);
    signal = 4'h0;
    step(1);
    signal[3] = 1'b1;
    step(1);
    chk("s5_ovf3", 32'(ovf), 32'h8);
    signal = 4'h0;
    reset  = 1'b1;
    step(1);
    chk("s5_rst_valid", 32'(evt_valid), 32'd0);
    chk("s5_rst_id",    32'(evt_id),    32'd0);
    chk("s5_rst_ovf",   32'(ovf),       32'd0);
    reset = 1'b0;
    step(3);
    chk("s5_no_pending", 32'(evt_valid), 32'd0);
    evt_ready = 1'b1;
    signal    = 4'b1001;
    step(2);
    chk("s5_first_ch0", 32'(evt_id), 32'd0);
    chk("s5_first_v",   32'(evt_valid), 32'd1);
    step(1);
    chk("s5_then_ch3", 32'(evt_id), 32'd3);

    // held-high level gives exactly one event
    do_reset();
    evt_ready = 1'b1;
    base      = hs_cnt;
    signal[3] = 1'b1;
    step(50);
    chk("s6_one_event", 32'(hs_cnt - base), 32'd1);
    chk("s6_no_ovf",    32'(ovf),           32'd0);
    chk("s6_idle",      32'(evt_valid),     32'd0);

`ifdef EDGE_ARB_PRESCALE_EN
    // PRESCALE=4: ticks fall on the 4th, 8th, 12th edge after reset
    do_reset();
    evt_ready = 1'b1;
    base      = hs_cnt;
    step(1);
    signal[0] = 1'b1;
    step(2);
    signal = 4'h0;
    step(3);
    chk("s4_between_ticks", 32'(hs_cnt - base), 32'd0);
    chk("s4_no_valid",      32'(evt_valid),     32'd0);
    step(1);
    signal[0] = 1'b1;
    step(2);
    chk("s4_straddle_v",  32'(evt_valid), 32'd1);
    chk("s4_straddle_id", 32'(evt_id),    32'd0);
    signal = 4'h0;
    step(6);
    chk("s4_one_event", 32'(hs_cnt - base), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_edge_event_arbiter
